// File: rtl/slink_generic_fc_tx_sm_pkg.sv
// slink_generic_fc_pkg: shared packet constants, FSM state encoding and header builder
// Contents: PKT_TYPE_DATA, header field offsets, state_t, hdr_field()
package slink_generic_fc_pkg;
    localparam logic [7:0] PKT_TYPE_DATA = 8'h40;
    localparam int HDR_TYPE_LSB = 0;
    localparam int HDR_SEQ_LSB  = 8;
    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA, ST_HALT} state_t;
    function automatic logic [15:0] hdr_field(input logic [7:0] seq);
        hdr_field = '0;
        hdr_field[HDR_SEQ_LSB +: 8]  = seq;
        hdr_field[HDR_TYPE_LSB +: 8] = PKT_TYPE_DATA;
    endfunction
endpackage

// File: rtl/slink_generic_fc_tx_sm_if.sv
// slink_generic_fc_tx_sm_if: replay-buffer, link-layer tx and far-end ack signals of the tx engine
// Modports: slave = tx engine, master = surrounding buffer / link layer
interface slink_generic_fc_tx_sm_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
);
    logic                  link_valid;
    logic [DATA_WIDTH-1:0] link_data;
    logic [ADDR_WIDTH:0]   link_cur_addr;
    logic                  link_advance;
    logic                  link_ack_update;
    logic [ADDR_WIDTH:0]   link_ack_addr;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_sop;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  rx_ack_valid;
    logic [ADDR_WIDTH:0]   rx_ack_seq;
    logic                  ack_err;
    logic                  ack_timeout;
    logic [ADDR_WIDTH:0]   outstanding;
    modport slave (
        input  link_valid, link_data, link_cur_addr, tx_ready, rx_ack_valid, rx_ack_seq,
        output link_advance, link_ack_update, link_ack_addr, tx_valid, tx_sop, tx_data,
               ack_err, ack_timeout, outstanding
    );
    modport master (
        output link_valid, link_data, link_cur_addr, tx_ready, rx_ack_valid, rx_ack_seq,
        input  link_advance, link_ack_update, link_ack_addr, tx_valid, tx_sop, tx_data,
               ack_err, ack_timeout, outstanding
    );
endinterface

// File: rtl/slink_generic_fc_tx_sm_ack_timer.sv
// slink_generic_fc_ack_timer: ack timeout counter with sticky timeout flag
// Ports: link_clk/link_reset_n clock and async active-low reset; run counts, clear zeroes the
// count, flush zeroes count and flag; timeout is the sticky flag
module slink_generic_fc_ack_timer #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic link_clk,
    input  logic link_reset_n,
    input  logic run,
    input  logic clear,
    input  logic flush,
    output logic timeout
);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);
    logic [CW-1:0] r_count;
    logic          r_timeout;
    always_ff @(posedge link_clk or negedge link_reset_n) begin
        if (!link_reset_n) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else if (flush) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (clear)
                r_count <= '0;
            else if (run && !r_timeout)
                r_count <= r_count + CW'(1);
            // flag rises on the same edge the count reaches ACK_TIMEOUT
            if (run && !clear && r_count == LAST)
                r_timeout <= 1'b1;
        end
    end
    assign timeout = r_timeout;
endmodule

// File: rtl/slink_generic_fc_tx_sm.sv
// slink_generic_fc_tx_sm: frames replay-buffer entries as header+payload beats, windows and validates acks
// Ports: link_clk, link_reset_n (async active-low), enable (low = flush/idle), bus (slave modport:
// replay buffer read side, link-layer tx beats, far-end acks, status outputs)
module slink_generic_fc_tx_sm
    import slink_generic_fc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 3,
    parameter int WINDOW      = 8,
    parameter int ACK_TIMEOUT = 1024
) (
    input logic                     link_clk,
    input logic                     link_reset_n,
    input logic                     enable,
    slink_generic_fc_tx_sm_if.slave bus
);
    typedef logic [ADDR_WIDTH:0] ptr_t;
    localparam ptr_t WIN = ptr_t'(WINDOW);
    state_t r_state;
    state_t w_state_nxt;
    ptr_t   r_acked_ptr;
    logic   r_ack_update;
    logic   r_ack_err;
    ptr_t   w_outs;
    ptr_t   w_ack_next;
    ptr_t   w_ack_d;
    logic   w_ack_ok;
    logic   w_timeout;
    assign w_outs     = bus.link_cur_addr - r_acked_ptr;
    assign w_ack_next = bus.rx_ack_seq + ptr_t'(1);
    assign w_ack_d    = w_ack_next - r_acked_ptr;
    // a cumulative ack must advance the pointer by 1..outstanding; anything else is stale or bogus
    assign w_ack_ok   = enable && bus.rx_ack_valid && w_ack_d != '0 && w_ack_d <= w_outs;
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_timeout ? ST_HALT :
                                   (bus.link_valid && w_outs < WIN) ? ST_HDR : ST_IDLE;
            ST_HDR:  w_state_nxt = bus.tx_ready ? ST_DATA : ST_HDR;
            ST_DATA: w_state_nxt = bus.tx_ready ? ST_IDLE : ST_DATA;
            default: w_state_nxt = ST_HALT;
        endcase
        if (!enable)
            w_state_nxt = ST_IDLE;
    end
    always_ff @(posedge link_clk or negedge link_reset_n) begin
        if (!link_reset_n) begin
            r_state      <= ST_IDLE;
            r_acked_ptr  <= '0;
            r_ack_update <= 1'b0;
            r_ack_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_acked_ptr  <= !enable ? '0 : w_ack_ok ? w_ack_next : r_acked_ptr;
            r_ack_update <= w_ack_ok;
            r_ack_err    <= enable && bus.rx_ack_valid && !w_ack_ok;
        end
    end
    slink_generic_fc_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .link_clk     (link_clk),
        .link_reset_n (link_reset_n),
        .run          (enable && w_outs != '0 && !w_ack_ok),
        .clear        (w_outs == '0 || w_ack_ok),
        .flush        (!enable),
        .timeout      (w_timeout)
    );
    assign bus.tx_valid        = r_state == ST_HDR || r_state == ST_DATA;
    assign bus.tx_sop          = r_state == ST_HDR;
    assign bus.tx_data         = r_state == ST_DATA ? bus.link_data :
                                 DATA_WIDTH'(hdr_field(8'(bus.link_cur_addr)));
    assign bus.link_advance    = r_state == ST_DATA && bus.tx_ready;
    assign bus.link_ack_update = r_ack_update;
    assign bus.link_ack_addr   = r_acked_ptr;
    assign bus.ack_err         = r_ack_err;
    assign bus.ack_timeout     = w_timeout;
    assign bus.outstanding     = w_outs;
endmodule

// File: tb/tb_slink_generic_fc_tx_sm.sv
// tb_slink_generic_fc_tx_sm: directed vector table plus multi-cycle sequences for the tx engine
module tb_slink_generic_fc_tx_sm;
    logic link_clk;
    logic link_reset_n;
    logic enable;
    logic [3:0] wr_ptr;
    logic [31:0] hdrs[$];
    int n_tests;
    int n_fail;
    slink_generic_fc_tx_sm_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus();
    slink_generic_fc_tx_sm #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .WINDOW(4), .ACK_TIMEOUT(16)) dut (
        .link_clk     (link_clk),
        .link_reset_n (link_reset_n),
        .enable       (enable),
        .bus          (bus)
    );
    typedef struct {
        logic rdy; logic av; logic [3:0] aseq;
        logic tv; logic sop; logic [31:0] td; logic adv; logic upd;
        logic [3:0] aaddr; logic err; logic [3:0] outs;
    } vec_t;
    vec_t vec[7];
    initial link_clk = 1'b0;
    always #5 link_clk = ~link_clk;
    function automatic logic [31:0] data_of(input logic [3:0] a);
        return 32'hDEADBEEF + 32'(a) * 32'h00010001;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // one clock; models the replay buffer (registered read, pointer bump on advance, zeroed when disabled)
    task automatic step();
        logic adv, en;
        logic [3:0] old;
        adv = bus.link_advance;
        en  = enable;
        old = bus.link_cur_addr;
        @(posedge link_clk);
        #1;
        bus.link_data = data_of(old);
        if (!en) begin
            bus.link_cur_addr = 4'd0;
            wr_ptr = 4'd0;
        end else if (adv) begin
            bus.link_cur_addr = old + 4'd1;
        end
        bus.link_valid = en && (bus.link_cur_addr != wr_ptr);
        #1;
    endtask
    task automatic push(input int n);
        wr_ptr = wr_ptr + 4'(n);
        bus.link_valid = enable && (bus.link_cur_addr != wr_ptr);
        #1;
    endtask
    task automatic flush();
        enable = 1'b0;
        step();
        enable = 1'b1;
        #1;
    endtask
    task automatic ack(input logic [3:0] seq);
        bus.rx_ack_valid = 1'b1;
        bus.rx_ack_seq = seq;
        #1;
        step();
        bus.rx_ack_valid = 1'b0;
        #1;
    endtask
    task automatic run(input int n);
        hdrs.delete();
        bus.tx_ready = 1'b1;
        #1;
        for (int i = 0; i < n; i++) begin
            if (bus.tx_valid && bus.tx_sop) hdrs.push_back(bus.tx_data);
            if (bus.tx_valid && !bus.tx_sop) chk("data_beat", bus.tx_data, data_of(bus.link_cur_addr));
            step();
        end
    endtask
    initial begin
        int cnt;
        n_tests = 0;
        n_fail = 0;
        link_reset_n = 1'b0;
        enable = 1'b0;
        wr_ptr = 4'd0;
        bus.link_valid = 1'b0;
        bus.link_data = 32'd0;
        bus.link_cur_addr = 4'd0;
        bus.tx_ready = 1'b0;
        bus.rx_ack_valid = 1'b0;
        bus.rx_ack_seq = 4'd0;
        repeat (3) @(posedge link_clk);
        #1;
        link_reset_n = 1'b1;
        enable = 1'b1;
        #1;
        chk("reset_outputs", {18'd0, bus.tx_valid, bus.tx_sop, bus.link_advance, bus.link_ack_update,
            bus.link_ack_addr, bus.ack_err, bus.ack_timeout, bus.outstanding}, 32'd0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.tx_valid) cnt++;
            step();
        end
        chk("idle_100_no_tx", cnt, 0);
        // single packet then valid ack, duplicate ack
        vec[0] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b0, 4'd0};
        vec[1] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 32'h00000040, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0};
        vec[2] = '{1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0};
        vec[3] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'd0, 1'b0, 4'd1};
        vec[4] = '{1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 4'd1, 1'b0, 4'd0};
        vec[5] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'd1, 1'b1, 4'd0};
        vec[6] = '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 4'd1, 1'b0, 4'd0};
        push(1);
        for (int i = 0; i < 7; i++) begin
            bus.tx_ready = vec[i].rdy;
            bus.rx_ack_valid = vec[i].av;
            bus.rx_ack_seq = vec[i].aseq;
            #1;
            chk($sformatf("vec%0d_ctl", i), {27'd0, bus.tx_valid, bus.tx_sop, bus.link_advance,
                bus.link_ack_update, bus.ack_err},
                {27'd0, vec[i].tv, vec[i].sop, vec[i].adv, vec[i].upd, vec[i].err});
            chk($sformatf("vec%0d_ack_addr", i), bus.link_ack_addr, vec[i].aaddr);
            chk($sformatf("vec%0d_outstanding", i), bus.outstanding, vec[i].outs);
            if (vec[i].tv) chk($sformatf("vec%0d_tx_data", i), bus.tx_data, vec[i].td);
            step();
        end
        bus.rx_ack_valid = 1'b0;
        // window of 4, six entries, then ack and wrap
        flush();
        push(6);
        run(14);
        chk("win_hdr_count", hdrs.size(), 4);
        for (int i = 0; i < 4 && i < hdrs.size(); i++)
            chk($sformatf("win_hdr%0d", i), hdrs[i], (32'(i) << 8) | 32'h40);
        chk("win_outstanding", bus.outstanding, 4);
        ack(4'd1);
        chk("win_ack_update", bus.link_ack_update, 1'b1);
        chk("win_ack_addr", bus.link_ack_addr, 4'd2);
        run(12);
        chk("win_more_hdrs", hdrs.size(), 2);
        if (hdrs.size() == 2) chk("win_hdr_seq5", hdrs[1], 32'h00000540);
        chk("win_outstanding2", bus.outstanding, 4);
        ack(4'd5);
        chk("win_ack_addr6", bus.link_ack_addr, 4'd6);
        push(4);
        run(15);
        chk("wrap_hdr_count", hdrs.size(), 4);
        if (hdrs.size() == 4) chk("wrap_hdr_seq8", hdrs[2], 32'h00000840);
        ack(4'd9);
        chk("wrap_ack_addr", bus.link_ack_addr, 4'd10);
        chk("wrap_outstanding", bus.outstanding, 4'd0);
        // out-of-range ack
        flush();
        push(2);
        run(8);
        chk("bad_outstanding", bus.outstanding, 4'd2);
        ack(4'd5);
        chk("bad_ack_err", bus.ack_err, 1'b1);
        chk("bad_no_update", bus.link_ack_update, 1'b0);
        chk("bad_ptr_kept", bus.link_ack_addr, 4'd0);
        // timeout
        flush();
        push(2);
        run(6);
        ack(4'd0);
        chk("to_ack_addr", bus.link_ack_addr, 4'd1);
        chk("to_outstanding", bus.outstanding, 4'd1);
        repeat (15) step();
        chk("to_not_yet", bus.ack_timeout, 1'b0);
        step();
        chk("to_set", bus.ack_timeout, 1'b1);
        push(2);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.tx_valid) cnt++;
            step();
        end
        chk("to_halt_no_tx", cnt, 0);
        chk("to_sticky", bus.ack_timeout, 1'b1);
        chk("to_addr_before_flush", bus.link_ack_addr, 4'd1);
        flush();
        chk("to_flush_flag", bus.ack_timeout, 1'b0);
        chk("to_flush_addr", bus.link_ack_addr, 4'd0);
        // tx_ready stall in DATA with an ack arriving
        push(2);
        run(3);
        step();
        chk("stall_hdr", bus.tx_data, 32'h00000140);
        step();
        bus.tx_ready = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.rx_ack_valid = 1'b0;
                #1;
                chk("stall_ack_update", bus.link_ack_update, 1'b1);
                chk("stall_ack_addr", bus.link_ack_addr, 4'd1);
            end
            chk($sformatf("stall%0d_ctl", i), {bus.tx_valid, bus.tx_sop, bus.link_advance}, 3'b100);
            chk($sformatf("stall%0d_data", i), bus.tx_data, data_of(4'd1));
            if (i == 1) begin
                bus.rx_ack_valid = 1'b1;
                bus.rx_ack_seq = 4'd0;
                #1;
            end
            step();
        end
        bus.tx_ready = 1'b1;
        #1;
        chk("stall_release_adv", bus.link_advance, 1'b1);
        chk("stall_release_data", bus.tx_data, data_of(4'd1));
        step();
        chk("stall_after_tv", bus.tx_valid, 1'b0);
        chk("stall_after_outs", bus.outstanding, 4'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
